// File: rtl/pipe_regs_pkg.sv
// pipe_regs_pkg
// Shared constants and helpers for the pipe_regs register chain.
//   DEFAULT_WIDTH  : default payload width in bits
//   DEFAULT_STAGES : default number of register stages
//   count_width()  : bit width of the optional occupancy count port
package pipe_regs_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 3;

  localparam int MIN_WIDTH  = 1;
  localparam int MAX_WIDTH  = 256;
  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 16;

  // Enough bits to represent 0..stages inclusive.
  function automatic int count_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_regs_stage.sv
// pipe_regs_stage
// One slot of the pipe_regs chain: a valid flag plus a payload register.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears valid and data)
//   i_flush    : drop the held entry at the next edge (data left untouched)
//   i_load     : capture i_data and mark the slot valid
//   i_clear    : slot's entry moved downstream; clear valid unless reloaded
//   i_data     : payload from the upstream slot (or the block input)
//   o_valid    : slot holds a valid entry
//   o_data     : held payload
module pipe_regs_stage
  import pipe_regs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load wins over clear so a slot that is emptied and refilled in the
  // same cycle stays valid. Data only moves on load; a stale payload in an
  // invalid slot is harmless because the valid flag is authoritative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_clear) begin
        r_valid <= 1'b0;
      end
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_regs.sv
// pipe_regs
// Valid/ready register chain of STAGES slots with bubble collapsing,
// stall (freeze) and flush (discard) controls.
// Parameters: WIDTH (1..256), STAGES (1..16).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   flush                 : discard every held entry at the next edge
//   stall                 : freeze the whole chain, no handshakes
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload
//   count                 : number of valid slots (only with PIPE_REGS_COUNT_EN)
// Optional feature: define PIPE_REGS_COUNT_EN to add the registered
// occupancy count output.
module pipe_regs
  import pipe_regs_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             stall,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data
`ifdef PIPE_REGS_COUNT_EN
  ,
  output logic [count_width(STAGES)-1:0]   count
`endif
);

  logic [STAGES-1:0] w_valid;
  logic [WIDTH-1:0]  w_data [STAGES];
  logic [STAGES-1:0] w_adv;
  logic              w_go;
  logic              w_accept;
  logic              r_rst_done;

  // Any flush or stall suppresses all movement and both handshakes.
  assign w_go = ~flush & ~stall;

  // Holds in_ready low until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // Advance ripples from the output back toward the input: a slot moves
  // if the slot ahead is empty or is itself moving. This is what collapses
  // bubbles and also makes in_ready combinational from out_ready.
  always_comb begin : p_adv
    logic [STAGES-1:0] adv_acc;
    adv_acc = '0;
    adv_acc[STAGES-1] = w_go & w_valid[STAGES-1] & out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_acc[k] = w_go & w_valid[k] & (~w_valid[k+1] | adv_acc[k+1]);
    end
    w_adv = adv_acc;
  end

  assign in_ready  = r_rst_done & w_go & (~w_valid[0] | w_adv[0]);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = w_valid[STAGES-1] & w_go;
  assign out_data  = w_data[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             w_load_k;
      logic [WIDTH-1:0] w_din_k;

      if (gi == 0) begin : g_head
        assign w_load_k = w_accept;
        assign w_din_k  = in_data;
      end else begin : g_body
        assign w_load_k = w_adv[gi-1];
        assign w_din_k  = w_data[gi-1];
      end

      pipe_regs_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_load  (w_load_k),
        .i_clear (w_adv[gi]),
        .i_data  (w_din_k),
        .o_valid (w_valid[gi]),
        .o_data  (w_data[gi])
      );
    end
  endgenerate

`ifdef PIPE_REGS_COUNT_EN
  localparam int CW = count_width(STAGES);

  logic [CW-1:0] r_count;
  logic          w_leave;

  // Occupancy only changes at the ends of the chain; internal bubble
  // movement leaves it unchanged.
  assign w_leave = w_adv[STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_accept) - CW'(w_leave);
    end
  end

  assign count = r_count;
`endif

endmodule
